// File: rtl/rom_boot_fetch.sv
// Boot ROM fetch engine: assembles 1..NHW halfwords from an async-read 16-bit ROM.
// Optional one-line prefetch buffer enabled by `define ROM_BOOT_FETCH_PREF_EN.
module rom_boot_fetch #(
  parameter int NHW  = 2,
  parameter int ADRW = 8,
  parameter int WAIT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [ADRW-1:0]     adr,
  input  logic                fcmdl,
  output logic [16*NHW-1:0]   dat,
  output logic                ack,
  output logic                busy,
  output logic [ADRW-1:0]     rom_adr,
  input  logic [15:0]         rom_dat,
  input  logic [15:0]         rom_siz,
  output logic [15:0]         romsiz
);

  // state | meaning
  // IDLE  | waiting for req; rom_adr holds its last value
  // ACC   | reading halfwords for the requested fetch
  // DONE  | one-cycle ack, dat valid
  // PREF  | background fetch of the next line into pbuf (prefetch build only)

  localparam int              DW    = 16 * NHW;
  localparam logic [ADRW-1:0] LMASK = ADRW'(NHW - 1);
  localparam logic [ADRW-1:0] LSTEP = ADRW'(NHW);
  localparam logic [1:0]      WLOAD = 2'(WAIT);
  localparam logic [1:0]      HLOAD = 2'(NHW - 1);

`ifdef ROM_BOOT_FETCH_PREF_EN
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE, S_PREF} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;
`endif

  state_t          state_q, state_d;
  logic [ADRW-1:0] rom_adr_q, rom_adr_d;
  logic [1:0]      wcnt_q, wcnt_d;
  logic [1:0]      hcnt_q, hcnt_d;
  logic            full_q, full_d;
  logic [DW-1:0]   sreg_q, sreg_d;
  logic [DW-1:0]   dat_q, dat_d;
`ifdef ROM_BOOT_FETCH_PREF_EN
  logic [ADRW-1:0] base_q, base_d;
  logic [ADRW-1:0] pline_q, pline_d;
  logic [DW-1:0]   pbuf_q, pbuf_d;
  logic            pvalid_q, pvalid_d;
`endif

  logic            start, stepping, last_cap, hit;
  logic [ADRW-1:0] req_base;
  logic [DW-1:0]   shifted;

  always_comb begin
    state_d   = state_q;
    rom_adr_d = rom_adr_q;
    wcnt_d    = wcnt_q;
    hcnt_d    = hcnt_q;
    full_d    = full_q;
    sreg_d    = sreg_q;
    dat_d     = dat_q;
`ifdef ROM_BOOT_FETCH_PREF_EN
    base_d    = base_q;
    pline_d   = pline_q;
    pbuf_d    = pbuf_q;
    pvalid_d  = pvalid_q;
`endif
    start    = 1'b0;
    hit      = 1'b0;
    shifted  = DW'({sreg_q, rom_dat});
    req_base = fcmdl ? (adr & ~LMASK) : adr;
    stepping = (state_q == S_ACC);
`ifdef ROM_BOOT_FETCH_PREF_EN
    if (state_q == S_PREF && !req) stepping = 1'b1;
    hit = fcmdl && pvalid_q && (req_base == pline_q);
`endif
    last_cap = stepping && (wcnt_q == '0) && (hcnt_q == '0);

    // Shared halfword sequencer for demand fetches and prefetches
    if (stepping) begin
      if (wcnt_q == '0) begin
        sreg_d = shifted;
        if (hcnt_q != '0) begin
          rom_adr_d = rom_adr_q + ADRW'(1);
          hcnt_d    = hcnt_q - 2'd1;
          wcnt_d    = WLOAD;
        end
      end else begin
        wcnt_d = wcnt_q - 2'd1;
      end
    end

    case (state_q)
      S_IDLE: start = req;
      S_ACC: begin
        if (last_cap) begin
          state_d = S_DONE;
          dat_d   = full_q ? shifted : DW'(rom_dat);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef ROM_BOOT_FETCH_PREF_EN
        if (full_q) begin
          state_d   = S_PREF;
          pline_d   = base_q + LSTEP;
          rom_adr_d = base_q + LSTEP;
          hcnt_d    = HLOAD;
          wcnt_d    = WLOAD;
          pvalid_d  = 1'b0;
        end
`endif
      end
`ifdef ROM_BOOT_FETCH_PREF_EN
      S_PREF: begin
        if (req) begin
          start = 1'b1;
        end else if (last_cap) begin
          pbuf_d   = shifted;
          pvalid_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // A request taken in IDLE (or aborting a prefetch) overrides the above
    if (start) begin
      full_d = fcmdl;
`ifdef ROM_BOOT_FETCH_PREF_EN
      base_d   = req_base;
      pvalid_d = 1'b0;
`endif
      if (hit) begin
        state_d = S_DONE;
`ifdef ROM_BOOT_FETCH_PREF_EN
        dat_d = pbuf_q;
`endif
      end else begin
        state_d   = S_ACC;
        rom_adr_d = req_base;
        hcnt_d    = fcmdl ? HLOAD : 2'd0;
        wcnt_d    = WLOAD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rom_adr_q <= '0;
      wcnt_q    <= '0;
      hcnt_q    <= '0;
      full_q    <= 1'b0;
      sreg_q    <= '0;
      dat_q     <= '0;
`ifdef ROM_BOOT_FETCH_PREF_EN
      base_q    <= '0;
      pline_q   <= '0;
      pbuf_q    <= '0;
      pvalid_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rom_adr_q <= rom_adr_d;
      wcnt_q    <= wcnt_d;
      hcnt_q    <= hcnt_d;
      full_q    <= full_d;
      sreg_q    <= sreg_d;
      dat_q     <= dat_d;
`ifdef ROM_BOOT_FETCH_PREF_EN
      base_q    <= base_d;
      pline_q   <= pline_d;
      pbuf_q    <= pbuf_d;
      pvalid_q  <= pvalid_d;
`endif
    end
  end

  assign dat     = dat_q;
  assign ack     = (state_q == S_DONE);
  assign busy    = (state_q == S_ACC) || (state_q == S_DONE);
  assign rom_adr = rom_adr_q;
  assign romsiz  = rom_siz;

endmodule
